// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues reads to a multi-cycle instruction memory
// and loads the IF/ID pipeline register. FETCH_BUSY back-pressures the PC unit
// so the PC only moves when an instruction is handed over, on the start cycle,
// or when a branch flush is taken. A one-entry buffer absorbs decode stalls.
module if_fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC,
    input  logic [31:0] PC_4,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic        FETCH_BUSY,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_PC_4,
    output logic [31:0] IF_ID_INSTR,
    output logic        IF_ID_VALID
);

    typedef enum logic [2:0] {StStart, StIssue, StWait, StHold, StDrain} state_t;

    state_t      state_q;
    logic [31:0] req_pc_q;
    logic [31:0] req_pc4_q;
    logic [31:0] buf_instr_q;

    logic        complete;
    logic        accept;
    logic [31:0] cur_pc;
    logic [31:0] cur_pc4;

    // Memory request and the address pair belonging to the current transaction
    always_comb begin
        IMEM_READ = (state_q == StIssue) || (state_q == StWait) || (state_q == StDrain);
        // In ISSUE the latch is not yet loaded, so the live PC is used directly
        IMEM_ADDR = (state_q == StIssue) ? PC : req_pc_q;
        cur_pc    = (state_q == StIssue) ? PC : req_pc_q;
        cur_pc4   = (state_q == StIssue) ? PC_4 : req_pc4_q;
        complete  = IMEM_READ && !IMEM_BUSYWAIT;
        accept    = !IF_ID_VALID || !STALL;
    end

    // PC unit back-pressure: low only when the PC is allowed to advance
    always_comb begin
        FETCH_BUSY = 1'b1;
        if (!RESET) begin
            case (state_q)
                StStart: FETCH_BUSY = 1'b0;
                StIssue,
                StWait: begin
                    if (FLUSH || (complete && accept)) FETCH_BUSY = 1'b0;
                end
                StHold: begin
                    if (FLUSH || !STALL) FETCH_BUSY = 1'b0;
                end
                StDrain: begin
                    if (FLUSH) FETCH_BUSY = 1'b0;
                end
                default: FETCH_BUSY = 1'b1;
            endcase
        end
    end

    // Fetch FSM, request latch, hold buffer and IF/ID register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StStart;
            req_pc_q    <= '0;
            req_pc4_q   <= '0;
            buf_instr_q <= '0;
            IF_ID_PC    <= '0;
            IF_ID_PC_4  <= '0;
            IF_ID_INSTR <= NOP_INSTR;
            IF_ID_VALID <= 1'b0;
        end else begin
            case (state_q)
                StStart: begin
                    state_q <= StIssue;
                end

                StIssue,
                StWait: begin
                    if (state_q == StIssue) begin
                        req_pc_q  <= PC;
                        req_pc4_q <= PC_4;
                    end
                    if (FLUSH) begin
                        IF_ID_VALID <= 1'b0;
                        IF_ID_INSTR <= NOP_INSTR;
                        buf_instr_q <= '0;
                        // An in-flight read must finish before a new one can start
                        state_q     <= complete ? StIssue : StDrain;
                    end else if (complete) begin
                        if (accept) begin
                            IF_ID_PC    <= cur_pc;
                            IF_ID_PC_4  <= cur_pc4;
                            IF_ID_INSTR <= IMEM_READDATA;
                            IF_ID_VALID <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            buf_instr_q <= IMEM_READDATA;
                            state_q     <= StHold;
                        end
                    end else begin
                        state_q <= StWait;
                    end
                end

                StHold: begin
                    if (FLUSH) begin
                        IF_ID_VALID <= 1'b0;
                        IF_ID_INSTR <= NOP_INSTR;
                        buf_instr_q <= '0;
                        state_q     <= StIssue;
                    end else if (!STALL) begin
                        IF_ID_PC    <= req_pc_q;
                        IF_ID_PC_4  <= req_pc4_q;
                        IF_ID_INSTR <= buf_instr_q;
                        IF_ID_VALID <= 1'b1;
                        state_q     <= StIssue;
                    end
                end

                StDrain: begin
                    if (FLUSH) begin
                        IF_ID_VALID <= 1'b0;
                        IF_ID_INSTR <= NOP_INSTR;
                    end
                    // Data from the abandoned read is dropped
                    if (complete) state_q <= StIssue;
                end

                default: state_q <= StStart;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a PC-unit model, a variable
// latency instruction memory and a scoreboard of expected IF/ID loads.
module tb_if_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] pc_r;
    logic [31:0] pc4;
    logic        STALL;
    logic        FLUSH;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        FETCH_BUSY;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_4;
    logic [31:0] IF_ID_INSTR;
    logic        IF_ID_VALID;

    logic [31:0] br_target;
    int          mem_lat;
    int          mem_cnt;

    int          n_cmp;
    int          n_fail;
    logic [31:0] sb_q[$];
    logic        mon_prev_valid;
    logic [31:0] mon_prev_pc;

    typedef struct {
        int          lat;
        logic [31:0] pc;
        int          cycles;
    } vec_t;

    vec_t vecs[5];

    if_fetch_unit #(
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (pc_r),
        .PC_4         (pc4),
        .STALL        (STALL),
        .FLUSH        (FLUSH),
        .IMEM_READ    (IMEM_READ),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .FETCH_BUSY   (FETCH_BUSY),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_PC_4   (IF_ID_PC_4),
        .IF_ID_INSTR  (IF_ID_INSTR),
        .IF_ID_VALID  (IF_ID_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // PC unit: steps by 4 or branches whenever BUSY_WAIT is low
    assign pc4 = pc_r + 32'd4;
    always_ff @(posedge CLK) begin
        if (RESET) pc_r <= 32'hFFFF_FFFC;
        else if (!FETCH_BUSY) pc_r <= FLUSH ? br_target : pc_r + 32'd4;
    end

    // Memory: busy for mem_lat cycles of each read, data = 0xA0000000 + addr
    assign IMEM_BUSYWAIT = IMEM_READ && (mem_cnt < mem_lat);
    assign IMEM_READDATA = 32'hA000_0000 + IMEM_ADDR;
    always_ff @(posedge CLK) begin
        if (IMEM_READ && IMEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard: every new valid IF/ID content must match the queue head
    initial begin
        mon_prev_valid = 1'b0;
        mon_prev_pc    = '0;
    end
    always @(negedge CLK) begin
        if (IF_ID_VALID === 1'b1 && (!mon_prev_valid || IF_ID_PC !== mon_prev_pc)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected_load: got pc %h expected no load", IF_ID_PC);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("sb_pc", IF_ID_PC, e);
                chk("sb_pc4", IF_ID_PC_4, e + 32'd4);
                chk("sb_instr", IF_ID_INSTR, 32'hA000_0000 + e);
            end
        end
        mon_prev_valid = (IF_ID_VALID === 1'b1);
        mon_prev_pc    = IF_ID_PC;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{lat: 0, pc: 32'h00, cycles: 1};
        vecs[1] = '{lat: 0, pc: 32'h04, cycles: 1};
        vecs[2] = '{lat: 3, pc: 32'h08, cycles: 4};
        vecs[3] = '{lat: 1, pc: 32'h0C, cycles: 2};
        vecs[4] = '{lat: 2, pc: 32'h10, cycles: 3};

        RESET     = 1'b1;
        STALL     = 1'b0;
        FLUSH     = 1'b0;
        br_target = '0;
        mem_lat   = 0;
        cyc();
        cyc();

        // Reset state
        chk("rst_valid", 32'(IF_ID_VALID), 32'd0);
        chk("rst_pc", IF_ID_PC, 32'd0);
        chk("rst_pc4", IF_ID_PC_4, 32'd0);
        chk("rst_instr", IF_ID_INSTR, 32'h0000_0013);
        chk("rst_read", 32'(IMEM_READ), 32'd0);
        chk("rst_busy", 32'(FETCH_BUSY), 32'd1);

        // Start cycle lets the PC step from -4 to 0
        RESET = 1'b0;
        settle();
        chk("start_busy", 32'(FETCH_BUSY), 32'd0);
        chk("start_read", 32'(IMEM_READ), 32'd0);
        cyc();

        // Table: one fetch per entry with a per-fetch memory latency
        foreach (vecs[i]) begin
            mem_lat = vecs[i].lat;
            sb_q.push_back(vecs[i].pc);
            settle();
            chk("tbl_read", 32'(IMEM_READ), 32'd1);
            n = 1;
            while (FETCH_BUSY === 1'b1 && n < 16) begin
                chk("tbl_addr_hold", IMEM_ADDR, vecs[i].pc);
                cyc();
                n++;
            end
            chk("tbl_addr", IMEM_ADDR, vecs[i].pc);
            chk("tbl_cycles", 32'(n), 32'(vecs[i].cycles));
            cyc();
            chk("tbl_ifid_pc", IF_ID_PC, vecs[i].pc);
            chk("tbl_ifid_valid", 32'(IF_ID_VALID), 32'd1);
        end

        // Stall: fetch of 0x14 completes into HOLD while IF/ID keeps 0x10
        mem_lat = 0;
        STALL   = 1'b1;
        sb_q.push_back(32'h14);
        settle();
        chk("stall_issue_busy", 32'(FETCH_BUSY), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("hold_read", 32'(IMEM_READ), 32'd0);
            chk("hold_busy", 32'(FETCH_BUSY), 32'd1);
            chk("hold_ifid", IF_ID_PC, 32'h10);
        end
        STALL = 1'b0;
        settle();
        chk("hold_release_busy", 32'(FETCH_BUSY), 32'd0);
        cyc();
        chk("hold_ifid_new", IF_ID_PC, 32'h14);
        chk("hold_next_addr", IMEM_ADDR, 32'h18);

        // Flush in WAIT of 0x18: branch to 0x40, read of 0x18 drained
        mem_lat = 3;
        settle();
        chk("fl_issue_busy", 32'(FETCH_BUSY), 32'd1);
        cyc();
        FLUSH     = 1'b1;
        br_target = 32'h40;
        settle();
        chk("fl_busy", 32'(FETCH_BUSY), 32'd0);
        chk("fl_addr", IMEM_ADDR, 32'h18);
        cyc();
        FLUSH = 1'b0;
        settle();
        chk("fl_valid", 32'(IF_ID_VALID), 32'd0);
        chk("fl_instr", IF_ID_INSTR, 32'h0000_0013);
        n = 0;
        while (IMEM_ADDR !== 32'h40 && n < 8) begin
            chk("drain_busy", 32'(FETCH_BUSY), 32'd1);
            chk("drain_read", 32'(IMEM_READ), 32'd1);
            cyc();
            n++;
        end
        chk("drain_cycles", 32'(n), 32'd2);
        mem_lat = 0;
        sb_q.push_back(32'h40);
        settle();
        chk("fl_target_busy", 32'(FETCH_BUSY), 32'd0);
        cyc();
        chk("fl_target_ifid", IF_ID_PC, 32'h40);

        // Flush and stall together in HOLD: flush wins, 0x44 never appears
        STALL = 1'b1;
        settle();
        chk("hf_issue_busy", 32'(FETCH_BUSY), 32'd1);
        cyc();
        FLUSH     = 1'b1;
        br_target = 32'h80;
        sb_q.push_back(32'h80);
        settle();
        chk("hf_busy", 32'(FETCH_BUSY), 32'd0);
        chk("hf_read", 32'(IMEM_READ), 32'd0);
        cyc();
        FLUSH = 1'b0;
        settle();
        chk("hf_valid", 32'(IF_ID_VALID), 32'd0);
        chk("hf_instr", IF_ID_INSTR, 32'h0000_0013);
        chk("hf_addr", IMEM_ADDR, 32'h80);
        // Stall with an invalid IF/ID must not block the load
        chk("hf_stall_invalid_busy", 32'(FETCH_BUSY), 32'd0);
        cyc();
        chk("hf_ifid", IF_ID_PC, 32'h80);
        STALL = 1'b0;
        sb_q.push_back(32'h84);
        settle();
        cyc();
        chk("hf_ifid_next", IF_ID_PC, 32'h84);

        // Reset during WAIT abandons the read; fetch restarts at 0
        mem_lat = 3;
        settle();
        cyc();
        chk("rw_read", 32'(IMEM_READ), 32'd1);
        chk("rw_addr", IMEM_ADDR, 32'h88);
        RESET = 1'b1;
        settle();
        chk("rw_busy", 32'(FETCH_BUSY), 32'd1);
        cyc();
        chk("rw_read_drop", 32'(IMEM_READ), 32'd0);
        chk("rw_valid", 32'(IF_ID_VALID), 32'd0);
        chk("rw_pc", IF_ID_PC, 32'd0);
        RESET   = 1'b0;
        mem_lat = 0;
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        settle();
        chk("rw_start_busy", 32'(FETCH_BUSY), 32'd0);
        chk("rw_start_read", 32'(IMEM_READ), 32'd0);
        cyc();
        chk("rw_first_addr", IMEM_ADDR, 32'h0);
        cyc();
        chk("rw_ifid0", IF_ID_PC, 32'h0);
        cyc();
        chk("rw_ifid4", IF_ID_PC, 32'h4);
        STALL = 1'b1;
        settle();
        cyc();
        cyc();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
